md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined `mips` core; sits in the E stage next to the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and holds HI/LO for mfhi/mflo readers.
- Drives a stall request to the hazard unit while an operation is in flight.
- Exercised end-to-end by the CPU testbench through code.txt programs.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (>=1)
- DIV_CYCLES, 10, busy duration for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage request, qualifies op for one cycle
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6-7 reserved
- a  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
- b  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in flight
- stall_req  output  1  combinational: busy OR (start AND op<=3)
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset:
  - reset=0 asynchronously clears hi, lo, busy, counter and latched operands to 0.
  - Reset asserted mid-operation aborts the operation; no HI/LO write ever follows.
- Accept:
  - At a rising edge with start=1, busy=0 and op in 0-3, latch a, b and op.
  - Load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3); busy=1 after that edge.
- Count:
  - Each following edge decrements the counter.
  - On the edge where the counter goes 1->0, write hi/lo and clear busy on that same edge.
  - busy is high for exactly LAT cycles.
  - The new hi/lo are visible the first cycle busy is low.
- Arithmetic, on latched operands:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = signed quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - divu: lo = unsigned quotient, hi = unsigned remainder.
- Divide by zero (b=0, div/divu): accepted, busy runs the full DIV_CYCLES, then hi and lo are left unchanged.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo (op 4/5) with start=1, busy=0:
  - Write hi (or lo) = a on that edge, single cycle.
  - busy stays 0; stall_req stays 0.
- start=1 while busy=1: ignored for every op, including mthi/mtlo; the in-flight operation is unaffected.
  - The hazard unit must hold the E stage via stall_req so the instruction re-presents after busy falls.
- Reserved op (6-7) with start=1: no effect.
- Back-to-back:
  - start is accepted in the cycle busy is low after completion.
  - No dead cycle is required between completion and the next accept.
- hi/lo outputs are registered.
  - During busy they show the old values.
  - mfhi/mflo stall via stall_req, so no bypass exists.
- FSM: IDLE (busy=0) -> RUN (busy=1) on accept of op 0-3; RUN -> IDLE when the counter hits 0; any state -> IDLE on reset.

Test Plan:
- Reset then mult, a=0xFFFFFFFD (-3), b=5, start pulsed one cycle -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu, a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; stall_req high in the start cycle and all busy cycles.
- div, a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu, a=7, b=2 -> lo=3, hi=1.
- mthi a=0x12345678, next cycle divu a=7, b=0 -> hi=0x12345678 immediately, busy 10 cycles, then hi=0x12345678 and lo=0 unchanged.
- mult 3*4 in flight, then start mtlo a=0xAAAA while busy -> mtlo ignored; at completion lo=12, hi=0.
- mult in flight, reset pulled low at cycle 2 -> hi=lo=0 and busy=0 immediately; no update after reset releases.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO for the E stage.
// Results are committed on the edge the busy window closes.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic        is_u;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] quo;
    logic [31:0] rem;

    assign stall_req = busy | (start & ~op[2]);

    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign prod_s = $signed({{32{a_q[31]}}, a_q})
                  * $signed({{32{b_q[31]}}, b_q});

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign is_u  = op_q[0];
    assign neg_a = ~is_u & a_q[31];
    assign neg_b = ~is_u & b_q[31];
    assign num   = neg_a ? (32'd0 - a_q) : a_q;
    assign den   = neg_b ? (32'd0 - b_q) : b_q;
    assign q     = (den == 32'd0) ? 32'd0 : num / den;
    assign r     = (den == 32'd0) ? 32'd0 : num % den;
    assign quo   = (neg_a ^ neg_b) ? (32'd0 - q) : q;
    assign rem   = neg_a ? (32'd0 - r) : r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        unique case (op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                op_q  <= op[1:0];
                                a_q   <= a;
                                b_q   <= b;
                                cnt   <= op[1] ? CNT_W'(DIV_CYCLES)
                                               : CNT_W'(MULT_CYCLES);
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                            3'd4: hi <= a;
                            3'd5: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (op_q[1]) begin
                            if (b_q != 32'd0) begin
                                hi <= rem;
                                lo <= quo;
                            end
                        end else if (is_u) begin
                            {hi, lo} <= prod_u;
                        end else begin
                            {hi, lo} <= prod_s;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int errs = 0;
    int checks = 0;
    int n;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .stall_req(stall_req),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request for a single edge; stall_req checked before the edge.
    task automatic go(input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic exp_stall);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        #1;
        check("stall_start", {31'd0, stall_req}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (busy && cyc < 40) begin
            @(posedge clk);
            #1;
            if (busy) cyc++;
        end
    endtask

    initial begin
        #2;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // mult -3 * 5
        go(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
        check("mult_busy0", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("mult_lat", 32'(n), 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // multu, stall held through the busy window, old HI/LO visible
        go(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        check("multu_old_lo", lo, 32'hFFFF_FFF1);
        n = 0;
        while (busy && n < 40) begin
            check("multu_stall", {31'd0, stall_req}, 32'd1);
            @(posedge clk);
            #1;
            n++;
        end
        check("multu_lat", 32'(n), 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // div -7 / 2, then divu back to back
        go(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(n);
        check("div_lat", 32'(n), 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        go(3'd3, 32'd7, 32'd2, 1'b1);
        check("divu_b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("divu_lat", 32'(n), 32'd10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        // fresh reset, mthi then divide by zero
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        go(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        go(3'd3, 32'd7, 32'd0, 1'b1);
        wait_done(n);
        check("dz_lat", 32'(n), 32'd10);
        check("dz_hi", hi, 32'h1234_5678);
        check("dz_lo", lo, 32'd0);

        // signed overflow
        go(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(n);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // mtlo while mult busy is ignored
        go(3'd0, 32'd3, 32'd4, 1'b1);
        @(posedge clk);
        #1;
        go(3'd5, 32'h0000_AAAA, 32'd0, 1'b1);
        check("mtlo_ign_lo", lo, 32'h8000_0000);
        wait_done(n);
        check("mtlo_ign_lat", 32'(n + 2), 32'd5);
        check("mtlo_ign_lo2", lo, 32'd12);
        check("mtlo_ign_hi", hi, 32'd0);

        // reserved op has no effect
        go(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
        check("rsv_busy", {31'd0, busy}, 32'd0);
        check("rsv_hi", hi, 32'd0);
        check("rsv_lo", lo, 32'd12);

        // reset mid-operation aborts with no later write
        go(3'd4, 32'h0000_0055, 32'd0, 1'b0);
        go(3'd0, 32'd3, 32'd4, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("arst_after_hi", hi, 32'd0);
        check("arst_after_lo", lo, 32'd0);
        check("arst_after_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
